// File: rtl/tron_pkg.sv
// Shared types and constants for the two-player trace game.
//   state_t  : round sequencer state (CLEAR, IDLE, PLAY, OVER)
//   dir_t    : player heading (UP, RIGHT, DOWN, LEFT)
//   winner_t : round result (none, P1, P2, draw)
//   GRID_W / GRID_H : playfield size in cells
//   GRID_STRIDE     : row stride of the trace memory address
package tron_pkg;

  localparam int GRID_W      = 160;
  localparam int GRID_H      = 120;
  localparam int GRID_STRIDE = 399;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_DRAW = 2'd3
  } winner_t;

  // Cells are 4 px wide: pixel coordinate is the cell index times four.
  function automatic logic [9:0] cell_to_px(input logic [7:0] i_cell);
    return {i_cell, 2'b00};
  endfunction

endpackage

// File: rtl/player_step.sv
// One-cell step for a single player (purely combinational).
//   i_x, i_y : current head cell
//   i_dir    : current heading
//   i_req    : requested heading (a reversal request is ignored)
//   o_dir    : heading to use for this move
//   o_x, o_y : next head cell (wraps on 8 bits; only meaningful when !o_wall)
//   o_wall   : next cell is outside the playfield
module player_step
  import tron_pkg::*;
(
  input  logic [7:0] i_x,
  input  logic [7:0] i_y,
  input  dir_t       i_dir,
  input  dir_t       i_req,
  output dir_t       o_dir,
  output logic [7:0] o_x,
  output logic [7:0] o_y,
  output logic       o_wall
);

  localparam logic [7:0] LAST_X = 8'(GRID_W - 1);
  localparam logic [7:0] LAST_Y = 8'(GRID_H - 1);

  always_comb begin
    // Opposite headings differ only in bit 1, so the reversal of i_dir is i_dir ^ 2.
    o_dir  = (i_req == dir_t'(i_dir ^ 2'd2)) ? i_dir : i_req;
    o_x    = i_x;
    o_y    = i_y;
    o_wall = 1'b0;
    // Wall is judged on the current cell so the 8-bit wrap never hides an exit.
    unique case (o_dir)
      UP: begin
        o_wall = (i_y == 8'd0);
        o_y    = i_y - 8'd1;
      end
      RIGHT: begin
        o_wall = (i_x == LAST_X);
        o_x    = i_x + 8'd1;
      end
      DOWN: begin
        o_wall = (i_y == LAST_Y);
        o_y    = i_y + 8'd1;
      end
      LEFT: begin
        o_wall = (i_x == 8'd0);
        o_x    = i_x - 8'd1;
      end
    endcase
  end

endmodule

// File: rtl/tron_game_ctrl.sv
// Round sequencer for the two-player trace grid.
// Clears the trace memory, waits for start, steps both players every
// TICK_FRAMES frames, writes the new heads and judges the round.
//   clock, reset (sync, active-high), start, frame_tick : control inputs
//   p1_dir, p2_dir         : requested headings (0 up, 1 right, 2 down, 3 left)
//   collision1, collision2 : trace memory read-back for the freshly written heads
//   clr_en, clr_addr       : clear-walk write strobe and address
//   wr_en                  : one-cycle head write strobe
//   x1, y1, x2, y2         : head pixel coordinates
//   state, winner          : sequencer state and round result
module tron_game_ctrl
  import tron_pkg::*;
#(
  parameter int TICK_FRAMES = 4,
  parameter int P1_X0       = 40,
  parameter int P1_Y0       = 60,
  parameter int P2_X0       = 120,
  parameter int P2_Y0       = 60,
  parameter int CLR_STRIDE  = GRID_STRIDE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        frame_tick,
  input  logic [1:0]  p1_dir,
  input  logic [1:0]  p2_dir,
  input  logic        collision1,
  input  logic        collision2,
  output logic        clr_en,
  output logic [16:0] clr_addr,
  output logic        wr_en,
  output logic [9:0]  x1,
  output logic [9:0]  y1,
  output logic [9:0]  x2,
  output logic [9:0]  y2,
  output logic [1:0]  state,
  output logic [1:0]  winner
);

  localparam logic [16:0] CLR_LAST = 17'(CLR_STRIDE * GRID_H - 1);
  localparam logic [3:0]  CNT_LAST = 4'(TICK_FRAMES - 1);
  localparam logic [7:0]  X1_0     = 8'(P1_X0);
  localparam logic [7:0]  Y1_0     = 8'(P1_Y0);
  localparam logic [7:0]  X2_0     = 8'(P2_X0);
  localparam logic [7:0]  Y2_0     = 8'(P2_Y0);

  state_t      r_state, w_state_nxt;
  winner_t     r_winner;
  logic        r_clr_en, r_wr_en;
  logic [16:0] r_clr_addr;
  logic [3:0]  r_frame_cnt;
  logic [7:0]  r_x1, r_y1, r_x2, r_y2;
  dir_t        r_dir1, r_dir2;
  logic        r_mv_p1, r_chk_p2;
  logic        r_wall1, r_wall2, r_headon;

  dir_t        w_dir1_nxt, w_dir2_nxt;
  logic [7:0]  w_x1_nxt, w_y1_nxt, w_x2_nxt, w_y2_nxt;
  logic        w_wall1, w_wall2, w_headon, w_move, w_loss1, w_loss2;

  player_step u_step1 (
    .i_x (r_x1), .i_y (r_y1), .i_dir (r_dir1), .i_req (dir_t'(p1_dir)),
    .o_dir (w_dir1_nxt), .o_x (w_x1_nxt), .o_y (w_y1_nxt), .o_wall (w_wall1)
  );

  player_step u_step2 (
    .i_x (r_x2), .i_y (r_y2), .i_dir (r_dir2), .i_req (dir_t'(p2_dir)),
    .o_dir (w_dir2_nxt), .o_x (w_x2_nxt), .o_y (w_y2_nxt), .o_wall (w_wall2)
  );

  // Move cycle M: the tick that completes a full move interval.
  assign w_move   = (r_state == PLAY) && frame_tick && (r_frame_cnt == CNT_LAST);
  assign w_headon = (w_x1_nxt == w_x2_nxt) && (w_y1_nxt == w_y2_nxt);
  // M+2: read-back for the heads written in M+1 is valid now.
  assign w_loss1  = r_chk_p2 && (r_wall1 || collision1 || r_headon);
  assign w_loss2  = r_chk_p2 && (r_wall2 || collision2 || r_headon);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      CLEAR: if (r_clr_en && (r_clr_addr == CLR_LAST)) w_state_nxt = IDLE;
      IDLE:  if (start) w_state_nxt = PLAY;
      PLAY:  if (w_loss1 || w_loss2) w_state_nxt = OVER;
      OVER:  if (start) w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= CLEAR;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_clr_en    <= 1'b0;
      r_clr_addr  <= '0;
      r_wr_en     <= 1'b0;
      r_frame_cnt <= '0;
      r_x1        <= X1_0;
      r_y1        <= Y1_0;
      r_x2        <= X2_0;
      r_y2        <= Y2_0;
      r_dir1      <= RIGHT;
      r_dir2      <= LEFT;
      r_mv_p1     <= 1'b0;
      r_chk_p2    <= 1'b0;
      r_wall1     <= 1'b0;
      r_wall2     <= 1'b0;
      r_headon    <= 1'b0;
      r_winner    <= WIN_NONE;
    end else begin
      r_wr_en  <= 1'b0;
      r_mv_p1  <= w_move;
      r_chk_p2 <= r_mv_p1;
      unique case (r_state)
        CLEAR: begin
          // First CLEAR cycle only raises the strobe so address 0 gets a full write cycle.
          if (!r_clr_en) begin
            r_clr_en <= 1'b1;
          end else if (r_clr_addr == CLR_LAST) begin
            r_clr_en   <= 1'b0;
            r_clr_addr <= '0;
          end else begin
            r_clr_addr <= r_clr_addr + 17'd1;
          end
        end
        IDLE: begin
          r_x1        <= X1_0;
          r_y1        <= Y1_0;
          r_x2        <= X2_0;
          r_y2        <= Y2_0;
          r_dir1      <= RIGHT;
          r_dir2      <= LEFT;
          r_frame_cnt <= '0;
          if (start) r_wr_en <= 1'b1;
        end
        PLAY: begin
          if (frame_tick)
            r_frame_cnt <= (r_frame_cnt == CNT_LAST) ? 4'd0 : r_frame_cnt + 4'd1;
          if (w_move) begin
            r_dir1   <= w_dir1_nxt;
            r_dir2   <= w_dir2_nxt;
            // A player leaving the grid keeps its last on-grid head.
            if (!w_wall1) begin
              r_x1 <= w_x1_nxt;
              r_y1 <= w_y1_nxt;
            end
            if (!w_wall2) begin
              r_x2 <= w_x2_nxt;
              r_y2 <= w_y2_nxt;
            end
            r_wall1  <= w_wall1;
            r_wall2  <= w_wall2;
            r_headon <= w_headon;
            r_wr_en  <= 1'b1;
          end
          if (w_loss1 && w_loss2) r_winner <= WIN_DRAW;
          else if (w_loss1)       r_winner <= WIN_P2;
          else if (w_loss2)       r_winner <= WIN_P1;
        end
        OVER: begin
          if (start) begin
            r_winner    <= WIN_NONE;
            r_x1        <= X1_0;
            r_y1        <= Y1_0;
            r_x2        <= X2_0;
            r_y2        <= Y2_0;
            r_dir1      <= RIGHT;
            r_dir2      <= LEFT;
            r_frame_cnt <= '0;
            r_clr_addr  <= '0;
            r_clr_en    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign clr_en   = r_clr_en;
  assign clr_addr = r_clr_addr;
  assign wr_en    = r_wr_en;
  assign x1       = cell_to_px(r_x1);
  assign y1       = cell_to_px(r_y1);
  assign x2       = cell_to_px(r_x2);
  assign y2       = cell_to_px(r_y2);
  assign state    = r_state;
  assign winner   = r_winner;

endmodule

// File: tb/tb_tron_game_ctrl.sv
// Bench for tron_game_ctrl. Instance A uses a short clear stride so several
// rounds fit in a short run; instance B keeps the full 399-cell stride and
// only walks its clear sequence in parallel.
module tb_tron_game_ctrl;

  localparam int STRIDE_A = 8;
  localparam int DEPTH_A  = STRIDE_A * 120;
  localparam int DEPTH_B  = 399 * 120;
  localparam int TICKS    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, ft, c1, c2;
  logic [1:0]  d1, d2;
  logic        clr_en_a, wr_en_a;
  logic [16:0] clr_addr_a;
  logic [9:0]  x1, y1, x2, y2;
  logic [1:0]  st, win;

  logic        rst_b, start_b;
  logic        clr_en_b, wr_en_b;
  logic [16:0] clr_addr_b;
  logic [9:0]  bx1, by1, bx2, by2;
  logic [1:0]  bst, bwin;

  tron_game_ctrl #(.TICK_FRAMES(TICKS), .CLR_STRIDE(STRIDE_A)) dut_a (
    .clock(clk), .reset(rst_a), .start(start_a), .frame_tick(ft),
    .p1_dir(d1), .p2_dir(d2), .collision1(c1), .collision2(c2),
    .clr_en(clr_en_a), .clr_addr(clr_addr_a), .wr_en(wr_en_a),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .state(st), .winner(win)
  );

  tron_game_ctrl dut_b (
    .clock(clk), .reset(rst_b), .start(start_b), .frame_tick(1'b0),
    .p1_dir(2'd1), .p2_dir(2'd3), .collision1(1'b0), .collision2(1'b0),
    .clr_en(clr_en_b), .clr_addr(clr_addr_b), .wr_en(wr_en_b),
    .x1(bx1), .y1(by1), .x2(bx2), .y2(by2), .state(bst), .winner(bwin)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the round: cells, headings, state and result.
  int mx[2], my[2], md[2];
  int mst, mwin;
  int dx[4] = '{0, 1, 0, -1};
  int dy[4] = '{-1, 0, 1, 0};

  // Full-stride clear walk of instance B, sampled on the falling edge.
  int b_cnt = 0;
  int b_bad = 0;
  always @(negedge clk) begin
    if (!rst_b && clr_en_b) begin
      if (clr_addr_b != 17'(b_cnt)) b_bad++;
      b_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mx[0] = 40;  my[0] = 60; md[0] = 1;
    mx[1] = 120; my[1] = 60; md[1] = 3;
    mwin  = 0;
  endtask

  task automatic chk_heads(input string tag);
    chk({tag, "_x1"}, 32'(x1), 32'(mx[0] * 4));
    chk({tag, "_y1"}, 32'(y1), 32'(my[0] * 4));
    chk({tag, "_x2"}, 32'(x2), 32'(mx[1] * 4));
    chk({tag, "_y2"}, 32'(y2), 32'(my[1] * 4));
  endtask

  // One move from the game rules: reversal refused, off-grid is a wall,
  // identical target cells are a head-on.
  task automatic model_move(input int r1, input int r2, output bit w1, output bit w2, output bit ho);
    int req[2], nd[2], nx[2], ny[2];
    bit wl[2];
    req[0] = r1; req[1] = r2;
    for (int p = 0; p < 2; p++) begin
      nd[p] = (req[p] == (md[p] + 2) % 4) ? md[p] : req[p];
      nx[p] = mx[p] + dx[nd[p]];
      ny[p] = my[p] + dy[nd[p]];
      wl[p] = (nx[p] < 0) || (nx[p] >= 160) || (ny[p] < 0) || (ny[p] >= 120);
    end
    ho = (nx[0] == nx[1]) && (ny[0] == ny[1]);
    for (int p = 0; p < 2; p++) begin
      md[p] = nd[p];
      if (!wl[p]) begin
        mx[p] = nx[p];
        my[p] = ny[p];
      end
    end
    w1 = wl[0];
    w2 = wl[1];
  endtask

  // A full move interval: TICKS-1 idle ticks with junk on the request and
  // read-back lines, then the move tick with the chosen requests, then the
  // read-back values k1/k2 presented only in the sampling cycle.
  task automatic do_move(input int r1, input int r2, input bit k1, input bit k2, input string tag);
    bit w1, w2, ho, l1, l2;
    for (int t = 0; t < TICKS - 1; t++) begin
      d1 = 2'($urandom_range(0, 3));
      d2 = 2'($urandom_range(0, 3));
      c1 = 1'($urandom_range(0, 1));
      c2 = 1'($urandom_range(0, 1));
      ft = 1'b1;
      cyc();
      ft = 1'b0;
      cyc();
    end
    d1 = 2'(r1);
    d2 = 2'(r2);
    ft = 1'b1;
    cyc();
    ft = 1'b0;
    d1 = 2'($urandom_range(0, 3));
    d2 = 2'($urandom_range(0, 3));
    c1 = 1'($urandom_range(0, 1));
    c2 = 1'($urandom_range(0, 1));
    model_move(r1, r2, w1, w2, ho);
    chk({tag, "_wr"}, 32'(wr_en_a), 32'd1);
    chk_heads(tag);
    cyc();
    c1 = k1;
    c2 = k2;
    chk({tag, "_wr_off"}, 32'(wr_en_a), 32'd0);
    cyc();
    c1 = 1'b0;
    c2 = 1'b0;
    l1 = w1 | k1 | ho;
    l2 = w2 | k2 | ho;
    if (l1 || l2) begin
      mst  = 3;
      mwin = (l1 && l2) ? 3 : (l1 ? 2 : 1);
    end
    chk({tag, "_state"}, 32'(st), 32'(mst));
    chk({tag, "_winner"}, 32'(win), 32'(mwin));
  endtask

  task automatic wait_clear(input string tag, input bit poke_start);
    int cnt = 0;
    int bad = 0;
    int n   = 0;
    while (st != 2'd1 && n < DEPTH_A + 20) begin
      if (clr_en_a) begin
        if (clr_addr_a != 17'(cnt)) bad++;
        cnt++;
      end
      start_a = poke_start && (n == 5 || n == 6);
      cyc();
      n++;
    end
    start_a = 1'b0;
    chk({tag, "_clr_cnt"}, 32'(cnt), 32'(DEPTH_A));
    chk({tag, "_clr_seq"}, 32'(bad), 32'd0);
    chk({tag, "_idle"}, 32'(st), 32'd1);
    chk({tag, "_clr_off"}, 32'(clr_en_a), 32'd0);
    mst = 1;
    model_reset();
    chk_heads({tag, "_idle"});
  endtask

  task automatic start_round(input string tag);
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    mst = 2;
    chk({tag, "_state"}, 32'(st), 32'd2);
    chk({tag, "_wr"}, 32'(wr_en_a), 32'd1);
    chk_heads(tag);
    cyc();
    chk({tag, "_wr_off"}, 32'(wr_en_a), 32'd0);
  endtask

  initial begin
    int n;
    rst_a = 1'b1; start_a = 1'b0; ft = 1'b0;
    d1 = 2'd1; d2 = 2'd3; c1 = 1'b0; c2 = 1'b0;
    rst_b = 1'b1; start_b = 1'b0;
    model_reset();
    mst = 0;
    cyc();
    cyc();
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_clr_en", 32'(clr_en_a), 32'd0);
    chk("rst_clr_addr", 32'(clr_addr_a), 32'd0);
    chk("rst_wr_en", 32'(wr_en_a), 32'd0);
    chk("rst_winner", 32'(win), 32'd0);
    chk_heads("rst");
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Round 1: straight step, reversal, turn, then P1 runs into the top wall.
    wait_clear("clr1", 1'b1);
    start_round("start1");
    do_move(1, 3, 1'b0, 1'b0, "step");
    chk("step_x1_px", 32'(x1), 32'd164);
    chk("step_x2_px", 32'(x2), 32'd476);
    do_move(3, 1, 1'b0, 1'b0, "reverse");
    chk("reverse_x1_px", 32'(x1), 32'd168);
    do_move(0, 3, 1'b0, 1'b0, "turn_up");
    chk("turn_up_y1_px", 32'(y1), 32'd236);
    for (int i = 0; i < 70 && mst == 2; i++) do_move(0, 3, 1'b0, 1'b0, "up");
    chk("wall_winner", 32'(win), 32'd2);
    chk("wall_y1", 32'(y1), 32'd0);
    for (int i = 0; i < 10; i++) begin
      ft = 1'(i % 2);
      d1 = 2'($urandom_range(0, 3));
      d2 = 2'($urandom_range(0, 3));
      c1 = 1'($urandom_range(0, 1));
      c2 = 1'($urandom_range(0, 1));
      cyc();
    end
    ft = 1'b0; c1 = 1'b0; c2 = 1'b0;
    chk("over_hold_state", 32'(st), 32'd3);
    chk("over_hold_winner", 32'(win), 32'd2);
    chk("over_hold_wr", 32'(wr_en_a), 32'd0);
    chk_heads("over_hold");

    // Round 2: random wandering, then P2 reads back its own head in P1's trail.
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    model_reset();
    chk("restart_state", 32'(st), 32'd0);
    chk("restart_winner", 32'(win), 32'd0);
    chk("restart_addr", 32'(clr_addr_a), 32'd0);
    chk_heads("restart");
    wait_clear("clr2", 1'b0);
    start_round("start2");
    for (int i = 0; i < 15 && mst == 2; i++)
      do_move($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0, "rand");
    do_move($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b1, "coll2");
    chk("coll2_winner", 32'(win), 32'd1);

    // Round 3: reset mid-play, start ignored during the clear, then a draw.
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    wait_clear("clr3", 1'b0);
    start_round("start3");
    for (int i = 0; i < 3; i++)
      do_move($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0, "pre_rst");
    ft = 1'b1;
    cyc();
    ft = 1'b0;
    rst_a = 1'b1;
    cyc();
    rst_a = 1'b0;
    model_reset();
    chk("midrst_state", 32'(st), 32'd0);
    chk("midrst_addr", 32'(clr_addr_a), 32'd0);
    chk("midrst_clr_en", 32'(clr_en_a), 32'd0);
    chk_heads("midrst");
    wait_clear("clr4", 1'b1);
    start_round("start4");
    do_move($urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 1'b1, "both");
    chk("both_winner", 32'(win), 32'd3);

    // Full-stride clear on instance B, with a start pulse it must ignore.
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    n = 0;
    while (bst != 2'd1 && n < DEPTH_B + 2000) begin
      cyc();
      n++;
    end
    chk("full_clr_cnt", 32'(b_cnt), 32'(DEPTH_B));
    chk("full_clr_seq", 32'(b_bad), 32'd0);
    chk("full_idle", 32'(bst), 32'd1);
    chk("full_x1", 32'(bx1), 32'd160);
    chk("full_x2", 32'(bx2), 32'd480);
    chk("full_winner", 32'(bwin), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
